cpu_halt_ctrl: RTL and testbench
================================

// Module: cpu_halt_ctrl
// PURPOSE
//  Upstream stage of the 6502 CPU wrapper; generates its halt_b and RDY inputs.
//  Arbitrates MARIA DMA requests against the CPU: halt is asserted only at a CPU read-cycle boundary.
//  Grants the bus to MARIA once the halt has settled, then releases it cleanly.
//  Also holds TIA WSYNC stalls, from the WSYNC strobe until the end of the line.
// PARAMETERS
//  GRANT_DELAY    1  cpu_ce strobes between halt_b falling and dma_grant rising (1..7)
//  MAX_WRITE_RUN  3  longest legal run of consecutive CPU write cycles; exceeding it while a DMA request waits sets err_wr
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   synchronous reset, active low
//  cpu_ce       in   1   one-clk strobe marking each CPU cycle boundary
//  cpu_rd       in   1   CPU read enable for the current cycle (1=read, 0=write)
//  dma_req      in   1   MARIA DMA request, level
//  dma_done     in   1   MARIA end-of-DMA, one-clk pulse
//  dma_grant    out  1   bus granted to MARIA
//  halt_b       out  1   CPU halt, active low, to the CPU wrapper
//  wsync_req    in   1   one-clk pulse: CPU wrote the TIA WSYNC register
//  hblank_end   in   1   one-clk pulse: TIA start of the next line
//  rdy          out  1   CPU RDY, to the CPU wrapper
//  err_wr       out  1   sticky: write run exceeded MAX_WRITE_RUN while dma_req was high
//  stall_cycles out  16  (HALT_STATS_EN only) count of cpu_ce strobes with halt_b=0 or rdy=0
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge): all registered outputs take these values on that edge.
//   - state=RUN, halt_b=1, rdy=1, dma_grant=0, err_wr=0.
//   - wsync_pend=0, write_run=0, delay counter=0, stall_cycles=0.
//   - Reset overrides every state; if asserted while HALTED, grant drops on the same edge.
//  All outputs are registered. FSM transitions occur only on clocks with cpu_ce=1, except dma_done.
//  DMA FSM (states RUN, HALT_ARM, HALTED, RELEASE):
//   - RUN: cpu_ce & dma_req & cpu_rd -> HALT_ARM, halt_b=0 on the next edge.
//     - Write cycle (cpu_rd=0) blocks the halt; state stays RUN.
//   - RUN: write_run counts consecutive write cycles and resets on any read cycle.
//     - write_run saturates at 7.
//     - write_run > MAX_WRITE_RUN with dma_req=1 sets err_wr (cleared only by reset).
//   - HALT_ARM: counts cpu_ce strobes.
//     - After GRANT_DELAY strobes: -> HALTED, dma_grant=1.
//     - dma_req falls first: -> RUN, halt_b=1 next edge, grant never asserted.
//   - HALTED: dma_done=1 or dma_req=0 -> RELEASE.
//     - On that edge dma_grant=0 and halt_b=1 (same edge, no cpu_ce needed).
//   - RELEASE: next cpu_ce -> RUN.
//     - A new dma_req is not accepted until RUN; this guarantees the CPU at least one cycle between DMAs.
//  WSYNC:
//   - wsync_req sets wsync_pend; hblank_end clears it.
//   - Simultaneous set and clear: set wins, so the stall lasts until the next hblank_end.
//   - rdy = ~wsync_pend (registered; one clk after the wsync_req pulse).
//   - WSYNC is independent of the DMA FSM; halt_b and rdy may both be low.
// CONFIGURATION
//  HALT_STATS_EN defined:
//   - stall_cycles is present.
//   - It increments on cpu_ce when halt_b=0 or rdy=0, and saturates at 16'hFFFF.
//  HALT_STATS_EN undefined:
//   - Port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  Package a7800_bus_pkg holds:
//   - typedef enum logic [1:0] halt_state_t {RUN, HALT_ARM, HALTED, RELEASE}.
//   - localparam WRITE_RUN_W = 3.
//  Sub-module cpu_wsync_latch holds the wsync_pend set/clear register and drives rdy.
//  The DMA FSM, write-run counter and stats counter live in cpu_halt_ctrl.
// TESTING
//  1. Reset: hold reset_n=0 3 clks -> halt_b=1, rdy=1, dma_grant=0, err_wr=0.
//  2. dma_req=1 on a read cycle, GRANT_DELAY=1:
//     - halt_b=0 next clk; dma_grant=1 after 1 further cpu_ce.
//     - dma_done pulse -> halt_b=1, dma_grant=0 same edge.
//  3. dma_req=1 during 3 writes then a read:
//     - halt_b stays 1 through the writes, falls after the read cpu_ce; err_wr=0.
//     - 4 writes with dma_req=1 -> err_wr=1.
//  4. dma_req dropped while in HALT_ARM -> dma_grant never asserts; halt_b=1 next clk.
//  5. wsync_req, then 200 clks later hblank_end:
//     - rdy=0 throughout, back to 1 one clk after hblank_end.
//     - wsync_req and hblank_end in the same clk -> rdy stays 0.
//  6. HALT_STATS_EN: 10-cycle DMA plus a 5-cycle WSYNC (non-overlapping) -> stall_cycles=15.
//     - Assert reset_n=0 mid-DMA -> dma_grant=0 and stall_cycles=0 on that edge.

Source files
------------

// File: rtl/cpu_halt_ctrl_pkg.sv
// Shared types for the 6502 halt/RDY controller.
// Holds the DMA FSM state encoding and the write-run counter width.
package a7800_bus_pkg;

  typedef enum logic [1:0] {
    RUN,
    HALT_ARM,
    HALTED,
    RELEASE
  } halt_state_t;

  localparam int WRITE_RUN_W = 3;

endpackage

// File: rtl/cpu_halt_ctrl_if.sv
// MARIA DMA handshake between the DMA engine and the CPU halt controller.
// master = MARIA side, slave = halt controller.
interface cpu_halt_ctrl_if;

  logic dma_req;
  logic dma_done;
  logic dma_grant;
  logic halt_b;

  modport master (
    output dma_req,
    output dma_done,
    input  dma_grant,
    input  halt_b
  );

  modport slave (
    input  dma_req,
    input  dma_done,
    output dma_grant,
    output halt_b
  );

endinterface

// File: rtl/cpu_wsync_latch.sv
// TIA WSYNC stall latch: holds RDY low from the WSYNC strobe to end of line.
// A set and clear in the same clock keeps the stall until the next line.
module cpu_wsync_latch (
  input  logic clk,
  input  logic reset_n,
  input  logic wsync_req,
  input  logic hblank_end,
  output logic rdy
);

  logic wsync_pend;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wsync_pend <= 1'b0;
    end else if (wsync_req) begin
      wsync_pend <= 1'b1;
    end else if (hblank_end) begin
      wsync_pend <= 1'b0;
    end
  end

  assign rdy = ~wsync_pend;

endmodule

// File: rtl/cpu_halt_ctrl.sv
// CPU halt/RDY controller: MARIA DMA arbitration plus WSYNC stall.
// Optional HALT_STATS_EN adds the stall_cycles counter port.
module cpu_halt_ctrl
  import a7800_bus_pkg::*;
#(
  parameter int GRANT_DELAY   = 1,
  parameter int MAX_WRITE_RUN = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_ce,
  input  logic              cpu_rd,
  cpu_halt_ctrl_if.slave    dma,
  input  logic              wsync_req,
  input  logic              hblank_end,
  output logic              rdy,
`ifdef HALT_STATS_EN
  output logic [15:0]       stall_cycles,
`endif
  output logic              err_wr
);

  localparam logic [2:0] GD =
    3'(GRANT_DELAY);
  localparam logic [WRITE_RUN_W-1:0] MWR =
    WRITE_RUN_W'(MAX_WRITE_RUN);

  halt_state_t            state;
  logic [2:0]             dly;
  logic [WRITE_RUN_W-1:0] write_run;
  logic [WRITE_RUN_W-1:0] wr_next;

  assign wr_next = (write_run == '1) ?
    write_run : write_run + 1'b1;

  cpu_wsync_latch u_wsync (
    .clk        (clk),
    .reset_n    (reset_n),
    .wsync_req  (wsync_req),
    .hblank_end (hblank_end),
    .rdy        (rdy)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= RUN;
      dma.halt_b    <= 1'b1;
      dma.dma_grant <= 1'b0;
      err_wr        <= 1'b0;
      dly           <= '0;
      write_run     <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (dma.dma_req && write_run > MWR)
            err_wr <= 1'b1;
          if (cpu_ce) begin
            if (cpu_rd) begin
              write_run <= '0;
              if (dma.dma_req) begin
                state      <= HALT_ARM;
                dma.halt_b <= 1'b0;
                dly        <= '0;
              end
            end else begin
              // writes cannot be halted; track how long MARIA is starved
              write_run <= wr_next;
              if (dma.dma_req && wr_next > MWR)
                err_wr <= 1'b1;
            end
          end
        end
        HALT_ARM: begin
          if (cpu_ce) begin
            if (!dma.dma_req) begin
              state      <= RUN;
              dma.halt_b <= 1'b1;
            end else if (dly + 3'd1 == GD) begin
              state         <= HALTED;
              dma.dma_grant <= 1'b1;
            end else begin
              dly <= dly + 3'd1;
            end
          end
        end
        HALTED: begin
          if (dma.dma_done || !dma.dma_req) begin
            state         <= RELEASE;
            dma.dma_grant <= 1'b0;
            dma.halt_b    <= 1'b1;
          end
        end
        RELEASE: begin
          if (cpu_ce)
            state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef HALT_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (cpu_ce && (!dma.halt_b || !rdy)
                 && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_halt_ctrl.sv
// Directed bench for cpu_halt_ctrl with an expectation queue scoreboard.
// Define HALT_STATS_EN to also cover stall_cycles.
module tb_cpu_halt_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cpu_ce = 1'b0;
  logic cpu_rd = 1'b1;
  logic wsync_req = 1'b0;
  logic hblank_end = 1'b0;
  logic rdy;
  logic err_wr;
`ifdef HALT_STATS_EN
  logic [15:0] stall_cycles;
`endif

  cpu_halt_ctrl_if dma();

  cpu_halt_ctrl #(
    .GRANT_DELAY   (1),
    .MAX_WRITE_RUN (3)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cpu_ce       (cpu_ce),
    .cpu_rd       (cpu_rd),
    .dma          (dma.slave),
    .wsync_req    (wsync_req),
    .hblank_end   (hblank_end),
    .rdy          (rdy),
`ifdef HALT_STATS_EN
    .stall_cycles (stall_cycles),
`endif
    .err_wr       (err_wr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        hb;
    logic        gr;
    logic        rd;
    logic        er;
    logic [15:0] st;
  } exp_t;

  exp_t q[$];
  logic e_hb = 1'b1;
  logic e_gr = 1'b0;
  logic e_rd = 1'b1;
  logic e_er = 1'b0;
  logic [15:0] e_st = 16'd0;
  int errors = 0;
  int checks = 0;

  task automatic push_exp(input string nm);
    exp_t e;
    e.name = nm;
    e.hb = e_hb;
    e.gr = e_gr;
    e.rd = e_rd;
    e.er = e_er;
    e.st = e_st;
    q.push_back(e);
  endtask

  // One clock: drive pulses, let the edge pass, clear pulses.
  task automatic cyc(input bit ce, input bit done,
                     input bit ws, input bit hb);
    cpu_ce = ce;
    dma.dma_done = done;
    wsync_req = ws;
    hblank_end = hb;
    @(posedge clk);
    #1;
    cpu_ce = 1'b0;
    dma.dma_done = 1'b0;
    wsync_req = 1'b0;
    hblank_end = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if ({dma.halt_b, dma.dma_grant, rdy, err_wr}
          !== {e.hb, e.gr, e.rd, e.er}) begin
        errors++;
        $display("FAIL %s: halt_b,grant,rdy,err got %b%b%b%b want %b%b%b%b",
                 e.name, dma.halt_b, dma.dma_grant, rdy, err_wr,
                 e.hb, e.gr, e.rd, e.er);
      end
`ifdef HALT_STATS_EN
      checks++;
      if (stall_cycles !== e.st) begin
        errors++;
        $display("FAIL %s: stall_cycles got %0d want %0d",
                 e.name, stall_cycles, e.st);
      end
`endif
    end
  end

  initial begin
    dma.dma_req = 1'b0;
    dma.dma_done = 1'b0;

    // reset
    reset_n = 1'b0;
    repeat (3) cyc(0, 0, 0, 0);
    push_exp("reset");
    reset_n = 1'b1;
    cyc(0, 0, 0, 0);
    push_exp("post_reset");

    // read-cycle DMA, grant, done, release spacing
    dma.dma_req = 1'b1;
    cpu_rd = 1'b1;
    cyc(1, 0, 0, 0); e_hb = 1'b0; push_exp("arm");
    cyc(1, 0, 0, 0); e_gr = 1'b1; push_exp("grant");
    cyc(0, 0, 0, 0); push_exp("grant_hold");
    cyc(0, 1, 0, 0); e_hb = 1'b1; e_gr = 1'b0; push_exp("done");
    cyc(1, 0, 0, 0); push_exp("release_no_rearm");
    cyc(1, 0, 0, 0); e_hb = 1'b0; push_exp("rearm");
    dma.dma_req = 1'b0;
    cyc(1, 0, 0, 0); e_hb = 1'b1; push_exp("abort_arm");
    cyc(1, 0, 0, 0); push_exp("abort_no_grant");

    // writes block halt; 3 ok, 4 sets err
    dma.dma_req = 1'b1;
    cpu_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0); push_exp("write_block");
    end
    cpu_rd = 1'b1;
    cyc(1, 0, 0, 0); e_hb = 1'b0; push_exp("read_after_3wr");
    dma.dma_req = 1'b0;
    cyc(1, 0, 0, 0); e_hb = 1'b1; push_exp("abort2");
    dma.dma_req = 1'b1;
    cpu_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0); push_exp("wr3_no_err");
    end
    cyc(1, 0, 0, 0); e_er = 1'b1; push_exp("err_4wr");
    dma.dma_req = 1'b0;
    cpu_rd = 1'b1;
    cyc(1, 0, 0, 0); push_exp("err_sticky");

    // WSYNC stall over a long line
    cyc(0, 0, 1, 0); e_rd = 1'b0; push_exp("wsync");
    for (int i = 0; i < 200; i++) begin
      cyc(0, 0, 0, 0);
      if (i % 50 == 49) push_exp("wsync_hold");
    end
    cyc(0, 0, 0, 1); e_rd = 1'b1; push_exp("hblank");
    cyc(0, 0, 1, 1); e_rd = 1'b0; push_exp("ws_hb_same");
    cyc(0, 0, 0, 0); push_exp("ws_hold2");
    cyc(0, 0, 0, 1); e_rd = 1'b1; push_exp("hblank2");

    // stall accounting: 10-strobe DMA then 5-strobe WSYNC
    reset_n = 1'b0;
    cyc(0, 0, 0, 0); e_er = 1'b0; e_st = 16'd0; push_exp("reset2");
    reset_n = 1'b1;
    dma.dma_req = 1'b1;
    cyc(1, 0, 0, 0); e_hb = 1'b0; push_exp("s_arm");
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 0, 0);
      e_st = e_st + 16'd1;
      e_gr = 1'b1;
    end
    push_exp("s_dma10");
    dma.dma_req = 1'b0;
    cyc(0, 1, 0, 0); e_hb = 1'b1; e_gr = 1'b0; push_exp("s_done");
    cyc(1, 0, 0, 0); push_exp("s_run");
    cyc(0, 0, 1, 0); e_rd = 1'b0; push_exp("s_wsync");
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0);
      e_st = e_st + 16'd1;
    end
    push_exp("s_ws5");
    cyc(0, 0, 0, 1); e_rd = 1'b1; push_exp("s_total");
    cyc(1, 0, 0, 0); push_exp("s_idle");

    // reset in the middle of a granted DMA
    dma.dma_req = 1'b1;
    cyc(1, 0, 0, 0); e_hb = 1'b0; push_exp("m_arm");
    cyc(1, 0, 0, 0); e_gr = 1'b1; e_st = e_st + 16'd1;
    push_exp("m_grant");
    reset_n = 1'b0;
    cyc(0, 0, 0, 0); e_hb = 1'b1; e_gr = 1'b0; e_st = 16'd0;
    push_exp("reset_mid_dma");
    reset_n = 1'b1;
    dma.dma_req = 1'b0;
    cyc(0, 0, 0, 0); push_exp("after_reset");

    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations unchecked, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
